// File: rtl/flex_fifo_pkg.sv
// flex_fifo_pkg
//   Shared helpers for the packet FIFO.
//   ptr_diff : occupancy between two wrap-bit pointers, modulo 2^(ptrw+1).
//   The pointer type depends on each instance's PTRW, so ptr_t is declared
//   locally in flex_pkt_fifo; a package typedef cannot follow a module
//   parameter.
package flex_fifo_pkg;

    // Pointers are passed zero-extended to 32 bits. The mask keeps the result
    // inside the pointer's own modulus, so wrap-around needs no special case.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          ptrw);
        logic [31:0] mask;
        mask = (32'd1 << (ptrw + 1)) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   DEPTH x NUMBITS register array with one write port and an asynchronous
//   read port. Contents reset to zero so the show-ahead output is defined
//   from reset onward.
//   clk, n_rst      : clock and asynchronous active-low reset
//   we, waddr, wdata: synchronous write port
//   raddr, rdata    : combinational read port
module fifo_ram #(
    parameter int NUMBITS = 8,
    parameter int DEPTH   = 64,
    parameter int AW      = 6
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [NUMBITS-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [NUMBITS-1:0] rdata
);

    logic [NUMBITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/flex_pkt_fifo.sv
// flex_pkt_fifo
//   Packet-holding FIFO between the USB receive packet decoder (writer) and
//   the AES block loader (reader). Writes land at a tentative pointer and
//   only become visible to the reader on w_commit; w_discard rolls a
//   CRC-failed packet back to the last commit.
//   clk, n_rst          : clock, asynchronous active-low reset
//   clear               : synchronous flush of pointers and error pulses
//   w_enable, w_data    : write at the tentative pointer
//   w_commit, w_discard : publish / roll back tentative writes
//   r_enable, r_data    : pop head word; r_data is show-ahead
//   empty, full, almost_empty, almost_full, count : status from pointers
//   overflow, underflow : one-cycle pulses on rejected write / read
module flex_pkt_fifo
    import flex_fifo_pkg::*;
#(
    parameter int NUMBITS   = 8,
    parameter int DEPTH     = 64,
    parameter int PTRW      = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               w_enable,
    input  logic [NUMBITS-1:0] w_data,
    input  logic               w_commit,
    input  logic               w_discard,
    input  logic               r_enable,
    output logic [NUMBITS-1:0] r_data,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [PTRW:0]      count,
    output logic               overflow,
    output logic               underflow
);

    typedef logic [PTRW:0] ptr_t;

    localparam ptr_t PTR_ONE     = ptr_t'(1);
    localparam ptr_t AFULL_LIM   = ptr_t'(AFULL_TH);
    localparam ptr_t AEMPTY_LIM  = ptr_t'(AEMPTY_TH);

    ptr_t wr_tent_q, wr_tent_d;
    ptr_t wr_cmt_q,  wr_cmt_d;
    ptr_t rd_q,      rd_d;
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    ptr_t tent_occ;
    logic wr_accept;
    logic rd_accept;
    logic ram_we;

    // Flags come straight from the registered pointers, so they describe the
    // state left by the previous edge; all accept decisions use these values.
    assign empty        = (wr_cmt_q == rd_q);
    assign full         = (wr_tent_q[PTRW] != rd_q[PTRW]) &&
                          (wr_tent_q[PTRW-1:0] == rd_q[PTRW-1:0]);
    assign count        = ptr_t'(ptr_diff(32'(wr_cmt_q), 32'(rd_q), PTRW));
    assign tent_occ     = ptr_t'(ptr_diff(32'(wr_tent_q), 32'(rd_q), PTRW));
    assign almost_full  = (tent_occ >= AFULL_LIM);
    assign almost_empty = (count <= AEMPTY_LIM);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_accept = w_enable && !full;
    assign rd_accept = r_enable && !empty;

    // Next-state pointers. clear beats everything; discard beats commit and
    // also drops a write presented in the same cycle. Commit takes the
    // post-write tentative pointer so a same-cycle write is published too.
    always_comb begin
        wr_tent_d   = wr_tent_q;
        wr_cmt_d    = wr_cmt_q;
        rd_d        = rd_q;
        overflow_d  = w_enable && full;
        underflow_d = r_enable && empty;
        ram_we      = 1'b0;

        if (clear) begin
            wr_tent_d   = '0;
            wr_cmt_d    = '0;
            rd_d        = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (rd_accept) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (w_discard) begin
                wr_tent_d = wr_cmt_q;
            end else begin
                if (wr_accept) begin
                    wr_tent_d = wr_tent_q + PTR_ONE;
                    ram_we    = 1'b1;
                end
                if (w_commit) begin
                    wr_cmt_d = wr_tent_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_tent_q   <= '0;
            wr_cmt_q    <= '0;
            rd_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_tent_q   <= wr_tent_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_q        <= rd_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .NUMBITS (NUMBITS),
        .DEPTH   (DEPTH),
        .AW      (PTRW)
    ) u_ram (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (ram_we),
        .waddr (wr_tent_q[PTRW-1:0]),
        .wdata (w_data),
        .raddr (rd_q[PTRW-1:0]),
        .rdata (r_data)
    );

endmodule

// File: tb/tb_flex_pkt_fifo.sv
// tb_flex_pkt_fifo
//   Scoreboard bench for flex_pkt_fifo (DEPTH=8, NUMBITS=8, AFULL_TH=6,
//   AEMPTY_TH=2). The reference keeps committed and tentative words as two
//   queues; every accepted read pushes the expected word onto expq and a
//   separate negedge monitor pops it when the DUT pops a word.
module tb_flex_pkt_fifo;

    localparam int NUMBITS   = 8;
    localparam int DEPTH     = 8;
    localparam int AFULL_TH  = 6;
    localparam int AEMPTY_TH = 2;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       w_enable;
    logic [7:0] w_data;
    logic       w_commit;
    logic       w_discard;
    logic       r_enable;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] cmtq[$];
    logic [7:0] tentq[$];
    logic [7:0] expq[$];
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    flex_pkt_fifo #(
        .NUMBITS   (NUMBITS),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .w_enable     (w_enable),
        .w_data       (w_data),
        .w_commit     (w_commit),
        .w_discard    (w_discard),
        .r_enable     (r_enable),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Status outputs against the reference queues as they stand after the
    // last edge.
    task automatic checkOutput();
        int cnt;
        int tocc;
        cnt  = cmtq.size();
        tocc = cmtq.size() + tentq.size();
        cmp("empty",        int'(empty),        int'(cnt == 0));
        cmp("full",         int'(full),         int'(tocc == DEPTH));
        cmp("count",        int'(count),        cnt);
        cmp("almost_full",  int'(almost_full),  int'(tocc >= AFULL_TH));
        cmp("almost_empty", int'(almost_empty), int'(cnt <= AEMPTY_TH));
        cmp("overflow",     int'(overflow),     int'(exp_ovf));
        cmp("underflow",    int'(underflow),    int'(exp_unf));
        if (cnt != 0) begin
            cmp("r_data_head", int'(r_data), int'(cmtq[0]));
        end
    endtask

    // Drives one cycle of inputs, checks current status, advances the
    // reference model across the coming edge, then steps to edge+1.
    task automatic applyStimulus(input logic we, input logic [7:0] wd,
                                 input logic cmt, input logic disc,
                                 input logic re, input logic clr);
        logic m_empty;
        logic m_full;
        w_enable  = we;
        w_data    = wd;
        w_commit  = cmt;
        w_discard = disc;
        r_enable  = re;
        clear     = clr;
        checkOutput();

        m_empty = (cmtq.size() == 0);
        m_full  = ((cmtq.size() + tentq.size()) == DEPTH);
        exp_ovf = we && m_full;
        exp_unf = re && m_empty;
        if (clr) begin
            cmtq.delete();
            tentq.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (re && !m_empty) begin
                expq.push_back(cmtq.pop_front());
            end
            if (disc) begin
                tentq.delete();
            end else begin
                if (we && !m_full) begin
                    tentq.push_back(wd);
                end
                if (cmt) begin
                    while (tentq.size() > 0) begin
                        cmtq.push_back(tentq.pop_front());
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever the DUT pops a word, it must be the next one the
    // reference released.
    always @(negedge clk) begin
        if (n_rst && !clear && r_enable && !empty) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL read_unexpected actual=0x%0h expected=none", r_data);
            end else begin
                cmp("read_data", int'(r_data), int'(expq.pop_front()));
            end
        end
    end

    initial begin
        n_rst     = 1'b0;
        clear     = 1'b0;
        w_enable  = 1'b0;
        w_data    = 8'h00;
        w_commit  = 1'b0;
        w_discard = 1'b0;
        r_enable  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_r_data", int'(r_data), 0);
        n_rst = 1'b1;

        // Uncommitted writes stay invisible until the commit pulse.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Discarded packet never reaches the reader.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Fill to full, overflow on a ninth write, drain, then underflow.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'(i == DEPTH - 1), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Streaming through the wrap point with concurrent read and write.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'(i > 0), 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // clear with 4 committed and 2 tentative words.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 1'(i == 3), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60),
                          8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 99) < 25),
                          1'($urandom_range(0, 99) < 6),
                          1'($urandom_range(0, 99) < 45),
                          1'($urandom_range(0, 99) < 2));
        end

        // Asynchronous reset in the middle of a write cycle.
        w_enable = 1'b1;
        w_data   = 8'h99;
        #2;
        n_rst = 1'b0;
        #1;
        cmp("rst_empty",        int'(empty),        1);
        cmp("rst_full",         int'(full),         0);
        cmp("rst_count",        int'(count),        0);
        cmp("rst_almost_empty", int'(almost_empty), 1);
        cmp("rst_almost_full",  int'(almost_full),  0);
        cmp("rst_overflow",     int'(overflow),     0);
        cmp("rst_underflow",    int'(underflow),    0);
        cmp("rst_r_data",       int'(r_data),       0);
        cmtq.delete();
        tentq.delete();
        expq.delete();
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        w_enable = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        cmp("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
